// File: rtl/nv_nvdla_csb_pkg.sv
// nv_nvdla_csb_pkg: shared CSB slave definitions (request field layout, response ids, response packing)
package nv_nvdla_csb_pkg;
    localparam int REQ_PD_W        = 63;
    localparam int REQ_ADDR_LSB    = 0;
    localparam int REQ_ADDR_W      = 22;
    localparam int REQ_WDAT_LSB    = 22;
    localparam int REQ_WDAT_W      = 32;
    localparam int REQ_WRITE_BIT   = 54;
    localparam int REQ_NPOSTED_BIT = 55;
    localparam int REQ_SRCPRIV_BIT = 56;
    localparam int REQ_WRBE_LSB    = 57;
    localparam int REQ_WRBE_W      = 4;
    localparam int REQ_LEVEL_LSB   = 61;
    localparam int REQ_LEVEL_W     = 2;
    localparam int RESP_PD_W       = 34;

    localparam logic RESP_ID_RD = 1'b0;
    localparam logic RESP_ID_WR = 1'b1;

    function automatic logic [RESP_PD_W-1:0] pack_resp(input logic id, input logic error, input logic [31:0] rdat);
        return {id, error, rdat};
    endfunction
endpackage

// File: rtl/nv_nvdla_cacc_csb_slave.sv
// nv_nvdla_cacc_csb_slave: CSB endpoint for CACC, 2-stage pipe turning requests into register strobes and responses
//   nvdla_core_clk/nvdla_core_rstn : clock, async active-low reset
//   req_pvld/req_prdy/req_pd       : request stream in (always ready)
//   resp_valid/resp_pd             : response stream out, 2 cycles after accept
//   reg_*                          : single-cycle register file access port
//   err_cnt_clr/err_cnt            : saturating out-of-window request counter
module nv_nvdla_cacc_csb_slave
    import nv_nvdla_csb_pkg::*;
#(
    parameter logic [21:0] BASE_WADDR = 22'h2400,
    parameter int          WIN_WORDS  = 1024,
    parameter int          ERR_CNT_W  = 8
) (
    input  logic                  nvdla_core_clk,
    input  logic                  nvdla_core_rstn,
    input  logic                  req_pvld,
    output logic                  req_prdy,
    input  logic [REQ_PD_W-1:0]   req_pd,
    output logic                  resp_valid,
    output logic [RESP_PD_W-1:0]  resp_pd,
    output logic [11:0]           reg_offset,
    output logic                  reg_rd_en,
    output logic                  reg_wr_en,
    output logic [31:0]           reg_wr_data,
    input  logic [31:0]           reg_rd_data,
    input  logic                  err_cnt_clr,
    output logic [ERR_CNT_W-1:0]  err_cnt
);
    logic                  vld_q;
    logic                  write_q;
    logic                  nposted_q;
    logic [REQ_ADDR_W-1:0] addr_q;
    logic [REQ_WDAT_W-1:0] wdat_q;
    logic [REQ_ADDR_W-1:0] off;
    logic                  in_win;
    logic                  err;
    logic                  send;
    logic [ERR_CNT_W-1:0]  err_cnt_nxt;
    logic                  unused_req;

    // wrbe, level and srcpriv carry no meaning for this slave
    assign unused_req = ^{req_pd[REQ_LEVEL_LSB +: REQ_LEVEL_W], req_pd[REQ_WRBE_LSB +: REQ_WRBE_W], req_pd[REQ_SRCPRIV_BIT]};

    assign req_prdy = 1'b1;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            vld_q     <= 1'b0;
            write_q   <= 1'b0;
            nposted_q <= 1'b0;
            addr_q    <= '0;
            wdat_q    <= '0;
        end else begin
            vld_q <= req_pvld;
            if (req_pvld) begin
                write_q   <= req_pd[REQ_WRITE_BIT];
                nposted_q <= req_pd[REQ_NPOSTED_BIT];
                addr_q    <= req_pd[REQ_ADDR_LSB +: REQ_ADDR_W];
                wdat_q    <= req_pd[REQ_WDAT_LSB +: REQ_WDAT_W];
            end
        end
    end

    // unsigned subtract: addresses below the base wrap high and fall out of the window
    always_comb begin
        off         = addr_q - BASE_WADDR;
        in_win      = off < REQ_ADDR_W'(WIN_WORDS);
        err         = vld_q & ~in_win;
        send        = vld_q & (~write_q | nposted_q);
        reg_rd_en   = vld_q & ~write_q & in_win;
        reg_wr_en   = vld_q & write_q & in_win;
        reg_offset  = {addr_q[9:0], 2'b00};
        reg_wr_data = wdat_q;
        err_cnt_nxt = err_cnt_clr ? ERR_CNT_W'(err) : (err && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            resp_valid <= 1'b0;
            resp_pd    <= '0;
            err_cnt    <= '0;
        end else begin
            resp_valid <= send;
            err_cnt    <= err_cnt_nxt;
            if (send)
                resp_pd <= pack_resp(write_q ? RESP_ID_WR : RESP_ID_RD, ~in_win, reg_rd_en ? reg_rd_data : 32'h0);
        end
    end
endmodule
